apb_requester: RTL and testbench

- Synthesizable, parametrised APB requester that turns single-command valid/ready requests into APB3/APB4 transfers.
- Sits between an internal control master (sequencer, CPU bridge) and the APB bus of the UART and peripheral register blocks.
- Adds, beyond a plain task-driven driver:
  - configurable address/data widths;
  - wait-state timeout with abort;
  - misalignment rejection;
  - a registered, back-pressurable response channel.

---
 rtl/apb_requester.sv | 176 +++++++++++++++++
 tb/tb_apb_requester.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_requester.sv
// apb_requester: turns single valid/ready commands into APB3/APB4 transfers, one outstanding at a time,
// with misalignment rejection, a wait-state timeout and a registered, back-pressurable response.
module apb_requester #(
   parameter int unsigned ADDR_W  = 12,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 8
) (
   input  logic                pclk,
   input  logic                preset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [DATA_W/8-1:0] cmd_strb,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                rsp_timeout,
   output logic [ADDR_W-1:0]   paddr,
   output logic                psel,
   output logic                penable,
   output logic                pwrite,
   output logic [DATA_W/8-1:0] pstrb,
   output logic [DATA_W-1:0]   pwdata,
   input  logic [DATA_W-1:0]   prdata,
   input  logic                pready,
   input  logic                pslverr
);
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned OFF_W  = (STRB_W > 1) ? $clog2(STRB_W) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic                pwrite_q, pwrite_d;
   logic [STRB_W-1:0]   pstrb_q, pstrb_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;
   logic                psel_q, psel_d;
   logic                penable_q, penable_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;
   logic                rsp_timeout_q, rsp_timeout_d;
   logic                misaligned_c;

   // Byte-lane offset bits must be zero for anything wider than a byte bus
   assign misaligned_c = (STRB_W > 1) && (cmd_addr[OFF_W-1:0] != '0);

   // State and datapath registers; reset clears everything, aborting any transfer in flight
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state_q       <= ST_IDLE;
         paddr_q       <= '0;
         pwrite_q      <= 1'b0;
         pstrb_q       <= '0;
         pwdata_q      <= '0;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         cnt_q         <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         paddr_q       <= paddr_d;
         pwrite_q      <= pwrite_d;
         pstrb_q       <= pstrb_d;
         pwdata_q      <= pwdata_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         cnt_q         <= cnt_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   // Next-state and next-output logic for the IDLE/SETUP/ACCESS/RESP sequence
   always_comb begin
      state_d       = state_q;
      paddr_d       = paddr_q;
      pwrite_d      = pwrite_q;
      pstrb_d       = pstrb_q;
      pwdata_d      = pwdata_q;
      psel_d        = psel_q;
      penable_d     = penable_q;
      cnt_d         = cnt_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;

      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               paddr_d  = cmd_addr;
               pwrite_d = cmd_write;
               pstrb_d  = cmd_write ? cmd_strb : '0;
               // Reads leave the last write data on pwdata
               if (cmd_write) pwdata_d = cmd_wdata;
               if (misaligned_c) begin
                  state_d       = ST_RESP;
                  rsp_valid_d   = 1'b1;
                  rsp_err_d     = 1'b1;
                  rsp_timeout_d = 1'b0;
                  rsp_rdata_d   = '0;
               end else begin
                  state_d = ST_SETUP;
                  psel_d  = 1'b1;
               end
            end
         end
         ST_SETUP: begin
            state_d   = ST_ACCESS;
            penable_d = 1'b1;
            cnt_d     = '0;
         end
         ST_ACCESS: begin
            // pready wins over a timeout reaching terminal count in the same cycle
            if (pready) begin
               state_d       = ST_RESP;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_err_d     = pslverr;
               rsp_timeout_d = 1'b0;
               rsp_rdata_d   = (pwrite_q || pslverr) ? '0 : prdata;
            end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT))) begin
               state_d       = ST_RESP;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_rdata_d   = '0;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Ready is a pure decode of IDLE, forced low while reset is held
   assign cmd_ready   = (state_q == ST_IDLE) && !preset;

   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;
   assign paddr       = paddr_q;
   assign psel        = psel_q;
   assign penable     = penable_q;
   assign pwrite      = pwrite_q;
   assign pstrb       = pstrb_q;
   assign pwdata      = pwdata_q;

endmodule

// File: tb/tb_apb_requester.sv
// tb_apb_requester: directed plus randomized transfers against a transaction-level reference model.
module tb_apb_requester;
   localparam int unsigned ADDR_W = 12;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = DATA_W / 8;

   logic pclk = 1'b0;
   logic preset, cmd_valid, cmd_write, rsp_ready, pready, pslverr;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata, prdata;
   logic [STRB_W-1:0] cmd_strb;

   // instance a: TIMEOUT=16, instance b: TIMEOUT=0 (same stimulus)
   logic cmd_ready_a, rsp_valid_a, rsp_err_a, rsp_timeout_a, psel_a, penable_a, pwrite_a;
   logic cmd_ready_b, rsp_valid_b, rsp_err_b, rsp_timeout_b, psel_b, penable_b, pwrite_b;
   logic [DATA_W-1:0] rsp_rdata_a, pwdata_a, rsp_rdata_b, pwdata_b;
   logic [ADDR_W-1:0] paddr_a, paddr_b;
   logic [STRB_W-1:0] pstrb_a, pstrb_b;

   logic sel_b;
   logic o_cmd_ready, o_rsp_valid, o_rsp_err, o_rsp_timeout, o_psel, o_penable, o_pwrite;
   logic [DATA_W-1:0] o_rsp_rdata, o_pwdata;
   logic [ADDR_W-1:0] o_paddr;
   logic [STRB_W-1:0] o_pstrb;

   int n_vec = 0;
   int n_err = 0;
   logic [DATA_W-1:0] last_wdata;

   always #5 pclk = ~pclk;

   apb_requester #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(16), .CNT_W(8)) u_dut_a (
      .pclk(pclk), .preset(preset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_a),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
      .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a),
      .rsp_timeout(rsp_timeout_a), .paddr(paddr_a), .psel(psel_a), .penable(penable_a),
      .pwrite(pwrite_a), .pstrb(pstrb_a), .pwdata(pwdata_a), .prdata(prdata), .pready(pready),
      .pslverr(pslverr));

   apb_requester #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(0), .CNT_W(8)) u_dut_b (
      .pclk(pclk), .preset(preset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_b),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
      .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
      .rsp_timeout(rsp_timeout_b), .paddr(paddr_b), .psel(psel_b), .penable(penable_b),
      .pwrite(pwrite_b), .pstrb(pstrb_b), .pwdata(pwdata_b), .prdata(prdata), .pready(pready),
      .pslverr(pslverr));

   assign o_cmd_ready   = sel_b ? cmd_ready_b   : cmd_ready_a;
   assign o_rsp_valid   = sel_b ? rsp_valid_b   : rsp_valid_a;
   assign o_rsp_err     = sel_b ? rsp_err_b     : rsp_err_a;
   assign o_rsp_timeout = sel_b ? rsp_timeout_b : rsp_timeout_a;
   assign o_rsp_rdata   = sel_b ? rsp_rdata_b   : rsp_rdata_a;
   assign o_psel        = sel_b ? psel_b        : psel_a;
   assign o_penable     = sel_b ? penable_b     : penable_a;
   assign o_pwrite      = sel_b ? pwrite_b      : pwrite_a;
   assign o_paddr       = sel_b ? paddr_b       : paddr_a;
   assign o_pstrb       = sel_b ? pstrb_b       : pstrb_a;
   assign o_pwdata      = sel_b ? pwdata_b      : pwdata_a;

   // Single comparison point: counts every check, reports any difference
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_apb(input string ph, input logic [ADDR_W-1:0] a, input logic w,
                          input logic [STRB_W-1:0] s);
      chk({ph, "_paddr"},  64'(o_paddr),  64'(a));
      chk({ph, "_pwrite"}, 64'(o_pwrite), 64'(w));
      chk({ph, "_pstrb"},  64'(o_pstrb),  64'(s));
      chk({ph, "_pwdata"}, 64'(o_pwdata), 64'(last_wdata));
   endtask

   // One command from IDLE to consumed response; called and returns just after a negedge in IDLE
   task automatic run_txn(input logic wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                          input logic [STRB_W-1:0] st, input int waits, input logic serr,
                          input logic [DATA_W-1:0] rd, input int bp, input int tmo);
      logic mis, to, exp_err;
      logic [DATA_W-1:0] exp_rdata;
      logic [STRB_W-1:0] exp_strb;
      int ncyc;
      mis = (addr[1:0] != 2'b00);
      to  = !mis && (tmo != 0) && (waits > tmo);
      if (wr) last_wdata = wd;
      exp_strb = wr ? st : '0;
      if (mis || to) begin
         exp_err = 1'b1;
         exp_rdata = '0;
      end else begin
         exp_err = serr;
         exp_rdata = (wr || serr) ? '0 : rd;
      end

      chk("idle_ready", 64'(o_cmd_ready), 64'd1);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = st;
      pready = 1'($urandom_range(0, 1)); pslverr = 1'($urandom_range(0, 1)); prdata = $urandom;
      @(negedge pclk);
      cmd_valid = 1'b0; cmd_addr = ADDR_W'($urandom); cmd_wdata = $urandom;
      chk("busy_ready", 64'(o_cmd_ready), 64'd0);
      if (!mis) begin
         chk("setup_psel", 64'(o_psel), 64'd1);
         chk("setup_pen", 64'(o_penable), 64'd0);
         chk("setup_rspv", 64'(o_rsp_valid), 64'd0);
         chk_apb("setup", addr, wr, exp_strb);
         pready = 1'($urandom_range(0, 1)); pslverr = 1'($urandom_range(0, 1));
         @(negedge pclk);
         ncyc = to ? tmo + 1 : waits + 1;
         for (int i = 0; i < ncyc; i++) begin
            chk("acc_psel", 64'(o_psel), 64'd1);
            chk("acc_pen", 64'(o_penable), 64'd1);
            chk("acc_rspv", 64'(o_rsp_valid), 64'd0);
            chk_apb("acc", addr, wr, exp_strb);
            pready  = (i == waits);
            pslverr = (i == waits) ? serr : 1'($urandom_range(0, 1));
            prdata  = (i == waits) ? rd : $urandom;
            @(negedge pclk);
         end
      end
      for (int j = 0; j <= bp; j++) begin
         chk("rsp_valid", 64'(o_rsp_valid), 64'd1);
         chk("rsp_err", 64'(o_rsp_err), 64'(exp_err));
         chk("rsp_timeout", 64'(o_rsp_timeout), 64'(to));
         chk("rsp_rdata", 64'(o_rsp_rdata), 64'(exp_rdata));
         chk("rsp_psel", 64'(o_psel), 64'd0);
         chk("rsp_pen", 64'(o_penable), 64'd0);
         chk("rsp_ready_lo", 64'(o_cmd_ready), 64'd0);
         if (!mis) chk_apb("hold", addr, wr, exp_strb);
         rsp_ready = (j == bp);
         pready = 1'($urandom_range(0, 1)); pslverr = 1'($urandom_range(0, 1)); prdata = $urandom;
         @(negedge pclk);
      end
      rsp_ready = 1'b0;
      chk("post_rspv", 64'(o_rsp_valid), 64'd0);
      chk("post_ready", 64'(o_cmd_ready), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic wr, serr;
      logic [ADDR_W-1:0] addr;
      int waits, bp;

      preset = 1'b1; sel_b = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; cmd_strb = '0; rsp_ready = 1'b0; pready = 1'b0; pslverr = 1'b0; prdata = '0;
      last_wdata = '0;
      repeat (3) @(negedge pclk);
      chk("rst_ready", 64'(o_cmd_ready), 64'd0);
      chk("rst_psel", 64'(o_psel), 64'd0);
      chk("rst_rspv", 64'(o_rsp_valid), 64'd0);
      chk("rst_paddr", 64'(o_paddr), 64'd0);
      preset = 1'b0;
      @(negedge pclk);
      chk("rel_ready", 64'(o_cmd_ready), 64'd1);

      // Directed cases
      run_txn(1'b1, 12'h010, 32'hA5A5_1234, 4'hF, 0, 1'b0, 32'h0, 0, 16);
      run_txn(1'b0, 12'h004, 32'h0, 4'hF, 3, 1'b0, 32'hDEAD_BEEF, 0, 16);
      run_txn(1'b1, 12'h008, 32'h0BAD_F00D, 4'h5, 1, 1'b1, 32'h0, 5, 16);
      run_txn(1'b0, 12'h00C, 32'h0, 4'h0, 2, 1'b1, 32'h1234_5678, 2, 16);
      run_txn(1'b1, 12'h006, 32'h7777_8888, 4'hF, 0, 1'b0, 32'h0, 1, 16);
      run_txn(1'b0, 12'h014, 32'h0, 4'h0, 16, 1'b0, 32'hCAFE_0016, 0, 16);

      // No-timeout instance rides out a long wait; the timeout instance waits in RESP alongside
      sel_b = 1'b1;
      run_txn(1'b0, 12'h018, 32'h0, 4'h0, 100, 1'b0, 32'h600D_0100, 0, 0);
      sel_b = 1'b0;

      // Stuck slave on the timeout instance
      run_txn(1'b0, 12'h01C, 32'h0, 4'h0, 40, 1'b0, 32'hFFFF_FFFF, 1, 16);

      // Reset during an ACCESS wait state
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h020; cmd_wdata = 32'h1357_9BDF;
      cmd_strb = 4'h3; pready = 1'b0;
      @(negedge pclk);
      cmd_valid = 1'b0;
      repeat (2) @(negedge pclk);
      chk("pre_rst_pen", 64'(o_penable), 64'd1);
      preset = 1'b1;
      #1;
      chk("arst_psel", 64'(o_psel), 64'd0);
      chk("arst_pen", 64'(o_penable), 64'd0);
      chk("arst_rspv", 64'(o_rsp_valid), 64'd0);
      chk("arst_ready", 64'(o_cmd_ready), 64'd0);
      chk("arst_pwdata", 64'(o_pwdata), 64'd0);
      @(negedge pclk);
      preset = 1'b0;
      last_wdata = '0;
      @(negedge pclk);
      chk("arel_ready", 64'(o_cmd_ready), 64'd1);
      chk("arel_psel", 64'(o_psel), 64'd0);
      run_txn(1'b1, 12'h030, 32'h2468_ACE0, 4'hC, 0, 1'b0, 32'h0, 0, 16);

      // Randomized traffic
      for (int t = 0; t < 40; t++) begin
         wr    = 1'($urandom_range(0, 1));
         addr  = ADDR_W'($urandom);
         if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
         waits = ($urandom_range(0, 7) == 0) ? int'($urandom_range(17, 20))
                                             : int'($urandom_range(0, 16));
         serr  = ($urandom_range(0, 3) == 0);
         bp    = int'($urandom_range(0, 3));
         run_txn(wr, addr, $urandom, STRB_W'($urandom), waits, serr, $urandom, bp, 16);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
